// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg: shared datapath width and operation encodings
package simple_processor_pkg;
   localparam int DATA_WIDTH = 32;
   typedef enum logic [3:0] {
      ADD  = 4'd0,
      ADDI = 4'd1,
      SUB  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      NOT  = 4'd5,
      SLL  = 4'd6,
      SLLI = 4'd7,
      SLR  = 4'd8,
      SLRI = 4'd9,
      NOP  = 4'd15
   } func_t;
endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: instruction, issue and writeback signals of the decode/issue stage
interface decode_issue_if #(parameter int NUM_REGS = 32);
   import simple_processor_pkg::*;
   localparam int RW = $clog2(NUM_REGS);
   logic [31:0]           instr_i;
   logic                  instr_valid_i;
   logic                  instr_ready_o;
   logic [DATA_WIDTH-1:0] rs1_data_o;
   logic [DATA_WIDTH-1:0] rs2_data_o;
   func_t                 func_o;
   logic [5:0]            imm_o;
   logic                  we_o;
   logic [RW-1:0]         rd_o;
   logic                  issue_valid_o;
   logic                  issue_ready_i;
   logic                  wb_valid_i;
   logic [RW-1:0]         wb_rd_i;
   logic [DATA_WIDTH-1:0] wb_data_i;
   modport slave (
      input  instr_i, instr_valid_i, issue_ready_i, wb_valid_i, wb_rd_i, wb_data_i,
      output instr_ready_o, rs1_data_o, rs2_data_o, func_o, imm_o, we_o, rd_o, issue_valid_o
   );
   modport master (
      output instr_i, instr_valid_i, issue_ready_i, wb_valid_i, wb_rd_i, wb_data_i,
      input  instr_ready_o, rs1_data_o, rs2_data_o, func_o, imm_o, we_o, rd_o, issue_valid_o
   );
endinterface

// File: rtl/decode_issue.sv
// decode_issue: scoreboarded decode/issue stage with register file and writeback bypass
module decode_issue
   import simple_processor_pkg::*;
#(parameter int NUM_REGS = 32) (
   input logic           clk_i,
   input logic           arst_ni,
   decode_issue_if.slave bus
);
   localparam int RW = $clog2(NUM_REGS);
   typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
   state_t                state_q;
   logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
   logic [NUM_REGS-1:0]   pend_q, pend_d, clr, set, live;
   func_t                 func, func_q;
   logic [RW-1:0]         rd, rs1, rs2, rd_q;
   logic [5:0]            imm_q;
   logic                  we, we_q, issue, hazard, ready, acc;
   logic [DATA_WIDTH-1:0] op1, op2, op1_q, op2_q;
   logic                  unused_bits;
   assign unused_bits = ^bus.instr_i[31:25];
   assign func = func_t'(bus.instr_i[3:0]);
   assign rd   = bus.instr_i[4 +: RW];
   assign rs1  = bus.instr_i[9 +: RW];
   assign rs2  = bus.instr_i[14 +: RW];
   assign we   = func inside {ADD, ADDI, SUB, OR, XOR, NOT, SLL, SLLI, SLR, SLRI} && rd != '0;
   // a register being written back this cycle no longer counts as pending
   always_comb begin
      clr = '0;
      set = '0;
      clr[bus.wb_rd_i] = bus.wb_valid_i;
      set[rd] = acc && we;
   end
   assign live   = pend_q & ~clr;
   assign pend_d = live | set;
   assign issue  = state_q == ISSUE;
   assign hazard = live[rs1] || live[rs2] || (we && live[rd]);
   assign ready  = arst_ni && !hazard && (!issue || bus.issue_ready_i);
   assign acc    = bus.instr_valid_i && ready;
   assign op1 = rs1 == '0 ? '0 : (bus.wb_valid_i && bus.wb_rd_i == rs1) ? bus.wb_data_i : rf_q[rs1];
   assign op2 = rs2 == '0 ? '0 : (bus.wb_valid_i && bus.wb_rd_i == rs2) ? bus.wb_data_i : rf_q[rs2];
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rf_q   <= '{default: '0};
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (bus.wb_valid_i && bus.wb_rd_i != '0) rf_q[bus.wb_rd_i] <= bus.wb_data_i;
      end
   end
   // ISSUE means the issue register holds an op; STALL means it is empty behind a hazard
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         func_q  <= func_t'(4'd0);
         imm_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         op1_q   <= '0;
         op2_q   <= '0;
      end else begin
         state_q <= acc ? ISSUE
                  : (issue && !bus.issue_ready_i) ? ISSUE
                  : (bus.instr_valid_i && hazard) ? STALL
                  : IDLE;
         if (acc) begin
            func_q <= func;
            imm_q  <= bus.instr_i[24:19];
            rd_q   <= rd;
            we_q   <= we;
            op1_q  <= op1;
            op2_q  <= op2;
         end
      end
   end
   assign bus.instr_ready_o = ready;
   assign bus.issue_valid_o = issue;
   assign bus.func_o        = func_q;
   assign bus.imm_o         = imm_q;
   assign bus.rd_o          = rd_q;
   assign bus.we_o          = we_q;
   assign bus.rs1_data_o    = op1_q;
   assign bus.rs2_data_o    = op2_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vectors checked against a register/scoreboard model every cycle
module tb_decode_issue;
   import simple_processor_pkg::*;
   logic clk = 1'b0;
   logic arst_ni = 1'b0;
   int checks = 0;
   int errors = 0;
   decode_issue_if #(.NUM_REGS(32)) bus ();
   decode_issue #(.NUM_REGS(32)) dut (.clk_i(clk), .arst_ni(arst_ni), .bus(bus));
   always #5 clk = ~clk;
   logic [31:0] m_regs [32];
   logic [31:0] m_pend = '0;
   logic        m_iv = 1'b0;
   logic [31:0] m_rs1 = '0, m_rs2 = '0;
   logic [3:0]  m_func = '0;
   logic [5:0]  m_imm = '0;
   logic        m_we = 1'b0;
   logic [4:0]  m_rd = '0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] mk(logic [3:0] f, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [5:0] imm);
      return {7'd0, imm, rs2, rs1, rd, f};
   endfunction
   function automatic logic writes(logic [31:0] ins);
      logic [3:0] f;
      f = ins[3:0];
      return f <= 4'd9 && ins[8:4] != 5'd0;
   endfunction
   function automatic logic [31:0] m_live();
      logic [31:0] p;
      p = m_pend;
      if (bus.wb_valid_i) p[bus.wb_rd_i] = 1'b0;
      return p;
   endfunction
   function automatic logic m_ready();
      logic [31:0] p;
      logic [31:0] ins;
      p = m_live();
      ins = bus.instr_i;
      if (p[ins[13:9]] || p[ins[18:14]] || (writes(ins) && p[ins[8:4]])) return 1'b0;
      return !m_iv || bus.issue_ready_i;
   endfunction
   function automatic logic [31:0] m_read(logic [4:0] r);
      if (r == 5'd0) return '0;
      if (bus.wb_valid_i && bus.wb_rd_i == r) return bus.wb_data_i;
      return m_regs[r];
   endfunction
   function automatic logic [31:0] m_pend_next();
      logic [31:0] p;
      p = m_live();
      if (bus.instr_valid_i && m_ready() && writes(bus.instr_i)) p[bus.instr_i[8:4]] = 1'b1;
      return p;
   endfunction
   always @(posedge clk or negedge arst_ni) begin
      if (!arst_ni) begin
         m_regs <= '{default: '0};
         m_pend <= '0;
         m_iv   <= 1'b0;
      end else begin
         m_pend <= m_pend_next();
         if (bus.wb_valid_i && bus.wb_rd_i != 5'd0) m_regs[bus.wb_rd_i] <= bus.wb_data_i;
         if (bus.instr_valid_i && m_ready()) begin
            m_iv   <= 1'b1;
            m_func <= bus.instr_i[3:0];
            m_imm  <= bus.instr_i[24:19];
            m_rd   <= bus.instr_i[8:4];
            m_we   <= writes(bus.instr_i);
            m_rs1  <= m_read(bus.instr_i[13:9]);
            m_rs2  <= m_read(bus.instr_i[18:14]);
         end else if (bus.issue_ready_i) m_iv <= 1'b0;
      end
   end
   always @(negedge clk) begin
      if (!arst_ni) begin
         chk("rst_valid", 32'(bus.issue_valid_o), 0);
         chk("rst_ready", 32'(bus.instr_ready_o), 0);
         chk("rst_rs1", bus.rs1_data_o, 0);
      end else begin
         chk("ready", 32'(bus.instr_ready_o), 32'(m_ready()));
         chk("valid", 32'(bus.issue_valid_o), 32'(m_iv));
         if (m_iv) begin
            chk("rs1", bus.rs1_data_o, m_rs1);
            chk("rs2", bus.rs2_data_o, m_rs2);
            chk("func", 32'(bus.func_o), 32'(m_func));
            chk("imm", 32'(bus.imm_o), 32'(m_imm));
            chk("we", 32'(bus.we_o), 32'(m_we));
            chk("rd", 32'(bus.rd_o), 32'(m_rd));
         end
      end
   end
   task automatic set_in(logic [31:0] ins, logic v, logic ir, logic wv, logic [4:0] wr, logic [31:0] wd);
      bus.instr_i = ins;
      bus.instr_valid_i = v;
      bus.issue_ready_i = ir;
      bus.wb_valid_i = wv;
      bus.wb_rd_i = wr;
      bus.wb_data_i = wd;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      set_in('0, 1'b0, 1'b1, 1'b0, 5'd0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(bus.issue_valid_o), 0);
      chk("reset_ready", 32'(bus.instr_ready_o), 0);
      arst_ni = 1'b1;
      #1 chk("ready_after_reset", 32'(bus.instr_ready_o), 1);
      tick();
      // writeback then read through the register file
      set_in('0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h10);
      tick();
      set_in(mk(ADD, 5'd5, 5'd3, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      tick();
      chk("add_valid", 32'(bus.issue_valid_o), 1);
      chk("add_rs1", bus.rs1_data_o, 32'h10);
      chk("add_rs2", bus.rs2_data_o, 0);
      chk("add_we", 32'(bus.we_o), 1);
      chk("add_rd", 32'(bus.rd_o), 5);
      set_in('0, 1'b0, 1'b1, 1'b0, 5'd0, '0);
      tick();
      chk("drain_valid", 32'(bus.issue_valid_o), 0);
      // RAW hazard released by writeback bypass
      set_in(mk(ADDI, 5'd4, 5'd0, 5'd0, 6'd3), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      tick();
      chk("addi_imm", 32'(bus.imm_o), 3);
      set_in(mk(ADD, 5'd6, 5'd4, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("raw_stall", 32'(bus.instr_ready_o), 0);
      tick();
      tick();
      chk("raw_stall_hold", 32'(bus.instr_ready_o), 0);
      set_in(mk(ADD, 5'd6, 5'd4, 5'd0, 6'd0), 1'b1, 1'b1, 1'b1, 5'd4, 32'h7);
      #1 chk("raw_bypass_ready", 32'(bus.instr_ready_o), 1);
      tick();
      chk("raw_bypass_rs1", bus.rs1_data_o, 32'h7);
      chk("raw_bypass_rd", 32'(bus.rd_o), 6);
      set_in(mk(ADD, 5'd6, 5'd0, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("waw_stall", 32'(bus.instr_ready_o), 0);
      set_in(mk(XOR, 5'd7, 5'd0, 5'd6, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("rs2_stall", 32'(bus.instr_ready_o), 0);
      set_in(mk(NOP, 5'd6, 5'd0, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("nowrite_no_waw", 32'(bus.instr_ready_o), 1);
      tick();
      chk("nop_we", 32'(bus.we_o), 0);
      set_in('0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h66);
      tick();
      // back-pressure holds the issue register
      set_in(mk(OR, 5'd8, 5'd3, 5'd0, 6'd9), 1'b1, 1'b0, 1'b0, 5'd0, '0);
      tick();
      set_in(mk(SUB, 5'd9, 5'd3, 5'd3, 6'd0), 1'b1, 1'b0, 1'b0, 5'd0, '0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", 32'(bus.instr_ready_o), 0);
         chk("bp_rd", 32'(bus.rd_o), 8);
         chk("bp_imm", 32'(bus.imm_o), 9);
         tick();
      end
      bus.issue_ready_i = 1'b1;
      #1 chk("bp_release", 32'(bus.instr_ready_o), 1);
      tick();
      chk("bp_next_rd", 32'(bus.rd_o), 9);
      chk("bp_next_rs2", bus.rs2_data_o, 32'h10);
      // register zero
      set_in('0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      set_in(mk(ADD, 5'd0, 5'd0, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      tick();
      chk("r0_rs1", bus.rs1_data_o, 0);
      chk("r0_we", 32'(bus.we_o), 0);
      set_in(mk(ADD, 5'd10, 5'd0, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("r0_not_pending", 32'(bus.instr_ready_o), 1);
      tick();
      // set wins over a same-edge clear
      set_in(mk(ADD, 5'd20, 5'd0, 5'd0, 6'd0), 1'b1, 1'b1, 1'b1, 5'd20, 32'h5);
      tick();
      set_in(mk(ADD, 5'd21, 5'd20, 5'd0, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("set_wins", 32'(bus.instr_ready_o), 0);
      tick();
      set_in(mk(ADD, 5'd21, 5'd20, 5'd0, 6'd0), 1'b1, 1'b1, 1'b1, 5'd20, 32'h9);
      tick();
      chk("set_wins_rs1", bus.rs1_data_o, 32'h9);
      // back-to-back independent ops
      for (int i = 0; i < 4; i++) begin
         set_in('0, 1'b0, 1'b1, 1'b1, 5'(11 + i), 32'h100 + 32'(i));
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(mk(SLL, 5'(15 + i), 5'(11 + i), 5'd0, 6'(i)), 1'b1, 1'b1, 1'b0, 5'd0, '0);
         #1 chk("b2b_ready", 32'(bus.instr_ready_o), 1);
         tick();
         chk("b2b_valid", 32'(bus.issue_valid_o), 1);
         chk("b2b_rs1", bus.rs1_data_o, 32'h100 + 32'(i));
      end
      // asynchronous reset with an op in flight
      set_in(mk(ADD, 5'd22, 5'd3, 5'd0, 6'd1), 1'b1, 1'b0, 1'b0, 5'd0, '0);
      tick();
      chk("pre_rst_valid", 32'(bus.issue_valid_o), 1);
      #1 arst_ni = 1'b0;
      #1 chk("arst_valid", 32'(bus.issue_valid_o), 0);
      chk("arst_ready", 32'(bus.instr_ready_o), 0);
      chk("arst_rs1", bus.rs1_data_o, 0);
      chk("arst_rd", 32'(bus.rd_o), 0);
      chk("arst_we", 32'(bus.we_o), 0);
      chk("arst_imm", 32'(bus.imm_o), 0);
      arst_ni = 1'b1;
      set_in(mk(ADD, 5'd23, 5'd3, 5'd21, 6'd0), 1'b1, 1'b1, 1'b0, 5'd0, '0);
      #1 chk("post_rst_ready", 32'(bus.instr_ready_o), 1);
      tick();
      chk("post_rst_rs1", bus.rs1_data_o, 0);
      chk("post_rst_rd", 32'(bus.rd_o), 23);
      set_in('0, 1'b0, 1'b1, 1'b0, 5'd0, '0);
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; register index width RW = clog2(NUM_REGS).
REQ-002 DATA_WIDTH, func_t and the ADD/ADDI/SUB/OR/XOR/NOT/SLL/SLLI/SLR/SLRI encodings shall come from simple_processor_pkg.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 arst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 instr_i  in  32  instruction word.
REQ-006 instr_valid_i  in  1  instr_i is valid.
REQ-007 instr_ready_o  out  1  the block accepts instr_i this cycle.
REQ-008 rs1_data_o  out  DATA_WIDTH  operand 1 to the execution unit.
REQ-009 rs2_data_o  out  DATA_WIDTH  operand 2 to the execution unit.
REQ-010 func_o  out  func_t  operation select.
REQ-011 imm_o  out  6  raw immediate.
REQ-012 we_o  out  1  the issued op writes rd.
REQ-013 rd_o  out  RW  destination register of the issued op.
REQ-014 issue_valid_o  out  1  the issue register holds a valid op.
REQ-015 issue_ready_i  in  1  the execution unit accepts the issued op.
REQ-016 wb_valid_i  in  1  writeback result valid.
REQ-017 wb_rd_i  in  RW  writeback destination.
REQ-018 wb_data_i  in  DATA_WIDTH  writeback data.

Function
REQ-019 Instruction fields: func = instr_i[3:0], rd = instr_i[8:4], rs1 = instr_i[13:9], rs2 = instr_i[18:14], imm = instr_i[24:19]; bits [31:25] are ignored.
REQ-020 The instruction shall write rd if and only if func is one of ADD, ADDI, SUB, OR, XOR, NOT, SLL, SLLI, SLR or SLRI and rd != 0; otherwise we = 0.
REQ-021 The register file holds NUM_REGS x DATA_WIDTH entries; register 0 always reads zero and ignores writes.
REQ-022 When wb_valid_i = 1 and wb_rd_i != 0, wb_data_i is written into the register file on the clock edge.
REQ-023 Scoreboard: one pending bit per register.
  - The bit for rd is set when a we = 1 op is accepted.
  - The bit for wb_rd_i is cleared on a write with wb_valid_i = 1.
  - If set and clear hit the same register on the same edge, set wins.
REQ-024 Hazard: the op is stalled if pending[rs1], pending[rs2] or (we and pending[rd]) is set.
  - Both register-read operands are checked for every func.
  - A pending bit being cleared by writeback in the same cycle does not cause a stall (bypass).
REQ-025 Operand read bypass: if wb_valid_i = 1 and wb_rd_i equals a nonzero source index, that operand takes wb_data_i in the same cycle.
REQ-026 Accept condition: instr_ready_o = !hazard and (!issue_valid_o or issue_ready_i), evaluated combinationally; an instruction is accepted when instr_valid_i and instr_ready_o are both 1.
REQ-027 On acceptance, the issue register loads func, imm, rd, we and the read/bypassed operands, and issue_valid_o = 1 on the next cycle (1-cycle latency).
REQ-028 When issue_valid_o and issue_ready_i are both 1 and no new instruction is accepted, issue_valid_o shall clear on the next cycle.
REQ-029 While issue_valid_o = 1 and issue_ready_i = 0, all issue outputs shall hold stable.
REQ-030 Back-to-back operation: one accepted instruction per cycle when there is no hazard and issue_ready_i = 1.
REQ-031 FSM with states IDLE, ISSUE and STALL:
  - IDLE -> ISSUE on acceptance.
  - ISSUE -> STALL when a valid instruction has a hazard.
  - STALL -> ISSUE when the hazard clears and the instruction is accepted.
  - ISSUE -> IDLE when the op drains and there is no new instruction.
  - The state is observable only through the handshake outputs.

Reset
REQ-032 While arst_ni = 0, all outputs are 0: issue_valid_o = 0, instr_ready_o = 0, we_o = 0, rd_o = 0, rs1_data_o = 0, rs2_data_o = 0, imm_o = 0, func_o = 0.
REQ-033 While arst_ni = 0, all register file entries are 0, all pending bits are 0 and the state is IDLE.
REQ-034 Reset asserted mid-operation discards the in-flight op without handshake.
REQ-035 instr_ready_o shall be 1 on the first cycle after arst_ni deasserts.

Verification
REQ-036 Writeback wb_rd = 3, data 0x0000_0010, then ADD rd = 5, rs1 = 3, rs2 = 0 -> next cycle: issue_valid_o = 1, rs1_data_o = 0x10, rs2_data_o = 0, we_o = 1, rd_o = 5.
REQ-037 ADDI rd = 4 then ADD rs1 = 4 with no writeback -> instr_ready_o = 0 until wb_valid_i with wb_rd = 4 and data 0x7; in that same cycle instr_ready_o = 1 and rs1_data_o = 0x7 next cycle.
REQ-038 issue_ready_i = 0 for 3 cycles with a valid op held -> issue outputs stable, instr_ready_o = 0; after issue_ready_i = 1, the next op issues the following cycle.
REQ-039 Writeback to rd = 0 with data 0xFFFF_FFFF, then read rs1 = 0 -> rs1_data_o = 0; an op with rd = 0 -> we_o = 0, no pending bit set.
REQ-040 Four independent ops with issue_ready_i held at 1 -> four consecutive cycles with issue_valid_o = 1 and operands in order.
REQ-041 arst_ni pulsed low while issue_valid_o = 1 -> all outputs 0 asynchronously, pending cleared, registers read 0.
